// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, NUM_WORDS frames packed into one W_OUT-bit beat.
// Single-entry output register; a beat completing while the held beat is stalled is dropped and flagged.
module uart_rx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
    parameter int W_OUT            = 16
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                rx,
    output logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0]   m_data,
    output logic                                                m_valid,
    input  logic                                                m_ready,
    output logic                                                frame_err,
    output logic                                                overrun
);
    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int NUM_STOP  = PACKET_SIZE - BITS_PER_WORD - 1;
    localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int BIT_MAX   = (BITS_PER_WORD > NUM_STOP) ? BITS_PER_WORD : NUM_STOP;
    localparam int BIT_W     = $clog2(BIT_MAX + 1);
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] HALF_PULSE = CNT_W'(CLOCKS_PER_PULSE / 2);
    localparam logic [CNT_W-1:0] FULL_PULSE = CNT_W'(CLOCKS_PER_PULSE);
    localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_W-1:0] LAST_STOP  = BIT_W'(NUM_STOP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    typedef logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] beat_t;

    logic                     rx_meta_q, rx_s_q;
    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic                     bad_q, bad_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    beat_t                    beat_q, beat_d;
    beat_t                    m_data_q, m_data_d;
    logic                     m_valid_q, m_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     overrun_q, overrun_d;
    logic                     frame_done, frame_bad;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        bad_d       = bad_q;
        idx_d       = idx_q;
        beat_d      = beat_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        frame_done  = 1'b0;
        frame_bad   = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // cnt counts clocks since the last sample point; samples land mid-bit
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = CNT_W'(1);
                    bit_d   = '0;
                    bad_d   = 1'b0;
                end
            end
            START: begin
                if (cnt_q == HALF_PULSE) begin
                    cnt_d   = CNT_W'(1);
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_PULSE) begin
                    cnt_d                    = CNT_W'(1);
                    shift_d                  = shift_q >> 1;
                    shift_d[BITS_PER_WORD-1] = rx_s_q;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_PULSE) begin
                    cnt_d = CNT_W'(1);
                    if (!rx_s_q) begin
                        bad_d = 1'b1;
                    end
                    if (bit_q == LAST_STOP) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                        frame_bad  = bad_q | ~rx_s_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_done) begin
            if (frame_bad) begin
                frame_err_d = 1'b1;
                idx_d       = '0;
            end else begin
                beat_d[idx_q] = shift_q;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    // a slot being read this cycle counts as free
                    if (!m_valid_q || m_ready) begin
                        m_data_d  = beat_d;
                        m_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            bad_q       <= 1'b0;
            idx_q       <= '0;
            beat_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            bad_q       <= bad_d;
            idx_q       <= idx_d;
            beat_q      <= beat_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
